// File: rtl/imem_loader.sv
// imem_loader: boot loader packing a byte stream into big-endian words written to instruction memory.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MAX_WORDS = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  S_DATA,
  input  logic        S_VALID,
  output logic        S_READY,
  output logic        MEM_WE,
  output logic [7:0]  MEM_ADDR,
  output logic [31:0] MEM_DI,
  output logic        CPU_RST,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_CSUM, ST_DONE, ST_ERR} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_DONE, ST_ERR} state_t;
`endif
  state_t state;
  logic [1:0] lane;
  logic [6:0] word_cnt, n_words;
  logic [7:0] addr;
  logic [23:0] acc;
  logic xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign S_READY = state == ST_LEN || state == ST_DATA || state == ST_CSUM;
`else
  assign S_READY = state == ST_LEN || state == ST_DATA;
`endif
  assign BUSY = S_READY;
  assign xfer = S_VALID && S_READY;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= ST_IDLE;
      lane     <= '0;
      word_cnt <= '0;
      n_words  <= '0;
      addr     <= '0;
      acc      <= '0;
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DI   <= '0;
      CPU_RST  <= 1'b1;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      MEM_WE <= 1'b0;
      case (state)
        ST_LEN: if (xfer) begin
          n_words <= S_DATA[6:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum    <= S_DATA;
`endif
          if (S_DATA != 8'd0 && int'(S_DATA) <= MAX_WORDS) state <= ST_DATA;
          else begin
            state <= ST_ERR;
            ERR   <= 1'b1;
          end
        end
        ST_DATA: if (xfer) begin
          lane <= lane + 2'd1;
          acc  <= {acc[15:0], S_DATA};
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum <= csum ^ S_DATA;
`endif
          if (lane == 2'd3) begin
            MEM_WE   <= 1'b1;
            MEM_DI   <= {acc, S_DATA};
            MEM_ADDR <= addr;
            addr     <= addr + 8'd4;
            word_cnt <= word_cnt + 7'd1;
            // leave DATA on the same edge as the last byte so CPU_RST drops with the final write
            if (word_cnt == n_words - 7'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state   <= ST_DONE;
              DONE    <= 1'b1;
              CPU_RST <= 1'b0;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: if (xfer) begin
          if (S_DATA == csum) begin
            state   <= ST_DONE;
            DONE    <= 1'b1;
            CPU_RST <= 1'b0;
          end else begin
            state <= ST_ERR;
            ERR   <= 1'b1;
          end
        end
`endif
        default: if (START) begin
          state    <= ST_LEN;
          lane     <= '0;
          word_cnt <= '0;
          addr     <= '0;
          CPU_RST  <= 1'b1;
          DONE     <= 1'b0;
          ERR      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum     <= '0;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; stimulus queues expected writes, a negedge monitor checks them.
module tb_imem_loader;
  logic CLK = 1'b0, RST = 1'b0, START = 1'b0, S_VALID = 1'b0;
  logic [7:0] S_DATA = '0;
  logic S_READY, MEM_WE, CPU_RST, BUSY, DONE, ERR;
  logic [7:0] MEM_ADDR;
  logic [31:0] MEM_DI;

  imem_loader dut (
    .CLK(CLK), .RST(RST), .START(START), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_READY(S_READY), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DI(MEM_DI),
    .CPU_RST(CPU_RST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {logic [7:0] a; logic [31:0] d; int c;} wr_t;
  wr_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  logic [31:0] img [64];
  bit pulse_start = 0, corrupt_csum = 0;
  int start_at_word = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // monitor: every write strobe must match the head of the scoreboard, including its cycle
  always @(negedge CLK) begin
    wr_t e;
    if (MEM_WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", MEM_ADDR, MEM_DI);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {24'd0, MEM_ADDR}, {24'd0, e.a});
        chk("wr_data", MEM_DI, e.d);
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gaps, input bit push = 0,
                      input logic [7:0] a = 0, input logic [31:0] d = 0);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge CLK);
    S_VALID = 1'b1;
    S_DATA = b;
    while (S_READY !== 1'b1 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (t == 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got S_READY %b expected 1", S_READY);
      S_VALID = 1'b0;
      return;
    end
    if (push) exp_q.push_back('{a, d, cyc + 1});
    if (pulse_start) START = 1'b1;
    @(negedge CLK);
    S_VALID = 1'b0;
    START = 1'b0;
    pulse_start = 0;
  endtask

  task automatic do_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("start_ready", S_READY, 1);
    chk("start_busy", BUSY, 1);
    chk("start_cpu_rst", CPU_RST, 1);
    chk("start_done", DONE, 0);
    chk("start_err", ERR, 0);
  endtask

  task automatic chk_reset();
    chk("rst_cpu_rst", CPU_RST, 1);
    chk("rst_ready", S_READY, 0);
    chk("rst_we", MEM_WE, 0);
    chk("rst_addr", {24'd0, MEM_ADDR}, 0);
    chk("rst_di", MEM_DI, 0);
    chk("rst_flags", {DONE, ERR, BUSY}, 0);
  endtask

  task automatic load(input int n, input bit gaps);
    logic [7:0] cs, b;
    bit ok = 1;
    do_start();
    cs = n[7:0];
    send(n[7:0], gaps);
    for (int k = 0; k < n; k++)
      for (int j = 3; j >= 0; j--) begin
        b = img[k][8*j +: 8];
        cs ^= b;
        if (k == start_at_word && j == 2) pulse_start = 1;
        send(b, gaps, j == 0, 8'(k * 4), img[k]);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("csum_busy", BUSY, 1);
    chk("csum_cpu_rst", CPU_RST, 1);
    ok = !corrupt_csum;
    send(corrupt_csum ? 8'h00 : cs, gaps);
`endif
    chk("end_done", DONE, ok);
    chk("end_err", ERR, !ok);
    chk("end_cpu_rst", CPU_RST, !ok);
    chk("end_busy", BUSY, 0);
    chk("end_ready", S_READY, 0);
    @(negedge CLK);
    chk("all_writes_seen", exp_q.size(), 0);
  endtask

  task automatic bad_len(input logic [7:0] n);
    do_start();
    send(n, 0);
    chk("badlen_err", ERR, 1);
    chk("badlen_cpu_rst", CPU_RST, 1);
    chk("badlen_busy", BUSY, 0);
    chk("badlen_done", DONE, 0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    S_VALID = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_reset();
    S_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    img[0] = 32'h08410001;
    img[1] = 32'h0C000002;
    load(2, 0);
    bad_len(8'h00);
    bad_len(8'h41);
    img[0] = 32'h13000093;
    load(1, 0);
    for (int k = 0; k < 64; k++) img[k] = {8'(k), ~8'(k), 8'h5A, 8'(k * 3)};
    start_at_word = 20;
    load(64, 1);
    start_at_word = -1;
    chk("last_addr", {24'd0, MEM_ADDR}, 32'hFC);
`ifdef IMEM_LOADER_CHECKSUM_EN
    img[0] = 32'hDEADBEEF;
    corrupt_csum = 1;
    load(1, 0);
    corrupt_csum = 0;
`endif
    img[0] = 32'h11223344;
    img[1] = 32'h55667788;
    do_start();
    send(8'd3, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0, 1, 8'h00, img[0]);
    send(8'h55, 0); send(8'h66, 0);
    RST = 1'b0;
    send(8'h77, 0);
    chk_reset();
    RST = 1'b1;
    S_VALID = 1'b1;
    S_DATA = 8'h88;
    repeat (4) @(negedge CLK);
    chk("after_rst_ready", S_READY, 0);
    S_VALID = 1'b0;
    chk("after_rst_queue", exp_q.size(), 0);
    do_start();
    send(8'd1, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
    RST = 1'b0;
    send(8'hDD, 0);
    chk_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("dropped_write_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
